ysyx_23060187_ifu: RTL

Instruction fetch unit for the NPC core and the producer side of the decode interface. It holds the PC, issues one word fetch at a time to instruction memory, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It accepts PC redirects from execute for jal, jalr and taken branches, and squashes any wrong-path fetch.

---
 rtl/ysyx_23060187_ifu.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_ifu.sv
// Purpose: NPC instruction fetch unit. Holds the PC, issues one word fetch at a
//   time to instruction memory and hands each fetched word and its PC to decode.
// Latency: inst_valid rises the cycle after imem_resp_valid. Minimum of 3 FSM
//   states (REQ, WAIT, HOLD) per instruction, plus any memory stall cycles.
// Backpressure: stalls in HOLD until decode accepts. No new fetch is issued
//   while an instruction is held, and at most one request is ever outstanding.
//
// Ports:
//   clk, rst_n                      core clock and async active-low reset
//   redirect_valid/redirect_pc      PC change from execute (bits [1:0] ignored)
//   imem_req_valid/ready/addr       fetch request channel (addr == pc)
//   imem_resp_valid/data            single-cycle fetch response
//   inst_valid/ready, inst, inst_pc instruction channel to decode
`timescale 1ns/1ps
module ysyx_23060187_ifu #(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            kill_q;        // outstanding response belongs to a wrong path
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] redirect_tgt;

  // Redirect targets are forced to word alignment.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // The address is driven from pc at all times; memory only samples it on the
  // handshake cycle, so a redirect while REQ is stalled retargets the request.
  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over every same-cycle event.
      pc_q <= redirect_tgt;
      case (state_q)
        BOOT: state_q <= REQ;
        REQ: begin
          // Handshake this cycle already went to the old address: squash it.
          if (imem_req_ready) begin
            kill_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            kill_q  <= 1'b0;
            state_q <= REQ;
          end else begin
            kill_q  <= 1'b1;
          end
        end
        HOLD: begin
          // Held instruction is dropped even if decode is accepting it now.
          inst_valid_q <= 1'b0;
          state_q      <= REQ;
        end
      endcase
    end else begin
      case (state_q)
        BOOT: state_q <= REQ;
        REQ: begin
          if (imem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              inst_q       <= imem_resp_data;
              inst_pc_q    <= pc_q;
              pc_q         <= pc_q + XLEN'(4);
              inst_valid_q <= 1'b1;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= REQ;
          end
        end
      endcase
    end
  end

endmodule
